// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the SRAM-style data/instruction port responder.
package data_sram_responder_pkg;

    localparam int unsigned LATENCY_MAX = 4;
    localparam int unsigned BYTE_LANES  = 4;
    localparam int unsigned WORD_W      = 32;

    // One slot of the read-response delay line.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [WORD_W-1:0] data;
    } sram_stage_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-style request/response bundle between the core (master) and the responder (slave).
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;

    logic                  sram_en;
    logic [BYTE_LANES-1:0] sram_wen;
    logic [31:0]           sram_addr;
    logic [WORD_W-1:0]     sram_wdata;
    logic [WORD_W-1:0]     sram_rdata;
    logic                  sram_rvalid;
    logic                  sram_err;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata, sram_rvalid, sram_err
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata, sram_rvalid, sram_err
    );
endinterface

// File: rtl/data_sram_responder_pipe.sv
// LATENCY-deep delay line of response stages; data only advances with a valid entry so the
// output holds its last read word while idle.
module sram_resp_pipe
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  sram_stage_t stage_i,
    output sram_stage_t stage_o
);

    sram_stage_t stage_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0].valid <= stage_i.valid;
            stage_q[0].err   <= stage_i.err;
            if (stage_i.valid) begin
                stage_q[0].data <= stage_i.data;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i].valid <= stage_q[i-1].valid;
                stage_q[i].err   <= stage_q[i-1].err;
                if (stage_q[i-1].valid) begin
                    stage_q[i].data <= stage_q[i-1].data;
                end
            end
        end
    end

    assign stage_o = stage_q[LATENCY-1];

endmodule

// File: rtl/data_sram_responder.sv
// Word-addressed SRAM responder with byte-lane writes and configurable read latency.
// Optional DATA_SRAM_PERF_CNT_EN adds read/write/error counters.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned BASE_WORD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DATA_SRAM_PERF_CNT_EN
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt,
    output logic [15:0]          err_cnt,
`endif
    data_sram_responder_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [29:0]       idx_c;
    logic              in_range_c;
    logic              rd_c;
    logic              wr_c;
    sram_stage_t       stage_in_c;
    sram_stage_t       pipe_out;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, bus.sram_addr[1:0]};

    // Address decode; a 30-bit unsigned compare makes addresses below BASE_WORD wrap out of range.
    always_comb begin
        idx_c            = bus.sram_addr[31:2] - 30'(BASE_WORD);
        in_range_c       = (idx_c >> ADDR_W) == 30'd0;
        rd_c             = bus.sram_en && (bus.sram_wen == '0);
        wr_c             = bus.sram_en && (bus.sram_wen != '0);
        stage_in_c       = '0;
        stage_in_c.valid = rd_c;
        stage_in_c.err   = bus.sram_en && !in_range_c;
        if (rd_c && in_range_c) begin
            stage_in_c.data = mem_q[idx_c[ADDR_W-1:0]];
        end
    end

    // Array contents survive reset, so this block has none.
    always_ff @(posedge clk) begin
        if (wr_c && in_range_c) begin
            for (int unsigned i = 0; i < BYTE_LANES; i++) begin
                if (bus.sram_wen[i]) begin
                    mem_q[idx_c[ADDR_W-1:0]][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
                end
            end
        end
    end

    sram_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .stage_i (stage_in_c),
        .stage_o (pipe_out)
    );

    assign bus.sram_rdata  = pipe_out.data;
    assign bus.sram_rvalid = pipe_out.valid;
    assign bus.sram_err    = pipe_out.err;

`ifdef DATA_SRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (rd_c) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_c && in_range_c) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (stage_in_c.err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance at LATENCY=1 and one at LATENCY=3.
module tb_data_sram_responder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    data_sram_responder_if bus1 ();
    data_sram_responder_if bus3 ();

`ifdef DATA_SRAM_PERF_CNT_EN
    logic [31:0] rd_cnt1, wr_cnt1, rd_cnt3, wr_cnt3;
    logic [15:0] err_cnt1, err_cnt3;
`endif

    data_sram_responder #(.ADDR_W(12), .LATENCY(1), .BASE_WORD(0)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
`ifdef DATA_SRAM_PERF_CNT_EN
        .rd_cnt  (rd_cnt1),
        .wr_cnt  (wr_cnt1),
        .err_cnt (err_cnt1),
`endif
        .bus     (bus1.slave)
    );

    data_sram_responder #(.ADDR_W(12), .LATENCY(3), .BASE_WORD(0)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
`ifdef DATA_SRAM_PERF_CNT_EN
        .rd_cnt  (rd_cnt3),
        .wr_cnt  (wr_cnt3),
        .err_cnt (err_cnt3),
`endif
        .bus     (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
        bus1.sram_en    = en;
        bus1.sram_wen   = wen;
        bus1.sram_addr  = addr;
        bus1.sram_wdata = wdata;
    endtask

    task automatic set3(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
        bus3.sram_en    = en;
        bus3.sram_wen   = wen;
        bus3.sram_addr  = addr;
        bus3.sram_wdata = wdata;
    endtask

    logic [31:0] exp3 [3];
    logic        saw_rvalid;

    initial begin
        checks   = 0;
        failures = 0;
        exp3[0]  = 32'hA0A0_A0A0;
        exp3[1]  = 32'hA1A1_A1A1;
        exp3[2]  = 32'hA2A2_A2A2;
        rst      = 1'b1;
        set1(1'b0, 4'h0, 32'h0, 32'h0);
        set3(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_rdata", bus1.sram_rdata, 32'h0);
        check("rst_rvalid", 32'(bus1.sram_rvalid), 32'h0);
        check("rst_err", 32'(bus1.sram_err), 32'h0);
        rst = 1'b0;
        tick();

        // LATENCY=1: write then read-after-write
        set1(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        tick();
        check("wr_no_rvalid", 32'(bus1.sram_rvalid), 32'h0);
        set1(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("raw_rvalid", 32'(bus1.sram_rvalid), 32'h1);
        check("raw_rdata", bus1.sram_rdata, 32'hDEAD_BEEF);
        check("raw_err", 32'(bus1.sram_err), 32'h0);
        set1(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("idle_rvalid", 32'(bus1.sram_rvalid), 32'h0);
        check("idle_hold", bus1.sram_rdata, 32'hDEAD_BEEF);

        // Byte-lane merge
        set1(1'b1, 4'hF, 32'h20, 32'h1122_3344);
        tick();
        set1(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        tick();
        set1(1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        check("lane_rdata", bus1.sram_rdata, 32'h11BB_33DD);
        set1(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Out of range, plus aliasing guard on word 0
        set1(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D);
        tick();
        set1(1'b1, 4'h0, 32'h4000, 32'h0);
        tick();
        check("oor_rd_rvalid", 32'(bus1.sram_rvalid), 32'h1);
        check("oor_rd_err", 32'(bus1.sram_err), 32'h1);
        check("oor_rd_rdata", bus1.sram_rdata, 32'h0);
        set1(1'b1, 4'hF, 32'h4000, 32'h5555_5555);
        tick();
        check("oor_wr_err", 32'(bus1.sram_err), 32'h1);
        check("oor_wr_rvalid", 32'(bus1.sram_rvalid), 32'h0);
        set1(1'b1, 4'h0, 32'h3FFC, 32'h0);
        tick();
        check("top_word_err", 32'(bus1.sram_err), 32'h0);
        check("top_word_rvalid", 32'(bus1.sram_rvalid), 32'h1);
        set1(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        check("oor_wr_noalias", bus1.sram_rdata, 32'h0BAD_F00D);
        set1(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("err_one_pulse", 32'(bus1.sram_err), 32'h0);
`ifdef DATA_SRAM_PERF_CNT_EN
        check("cnt_rd", rd_cnt1, 32'd5);
        check("cnt_wr", wr_cnt1, 32'd4);
        check("cnt_err", 32'(err_cnt1), 32'd2);
`endif

        // LATENCY=3: preload then three back-to-back reads
        for (int i = 0; i < 3; i++) begin
            set3(1'b1, 4'hF, 32'(4 * i), exp3[i]);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set3(1'b1, 4'h0, 32'(4 * k), 32'h0);
            else       set3(1'b0, 4'h0, 32'h0, 32'h0);
            tick();
            if (k < 2 || k == 5) begin
                check($sformatf("l3_rvalid_k%0d", k), 32'(bus3.sram_rvalid), 32'h0);
            end else begin
                check($sformatf("l3_rvalid_k%0d", k), 32'(bus3.sram_rvalid), 32'h1);
                check($sformatf("l3_rdata_k%0d", k), bus3.sram_rdata, exp3[k-2]);
            end
        end

        // Reset with two reads in flight
        set3(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        set3(1'b1, 4'h0, 32'h4, 32'h0);
        tick();
        set3(1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", 32'(bus3.sram_rvalid), 32'h0);
        check("rst_mid_rdata", bus3.sram_rdata, 32'h0);
        check("rst_mid_rdata1", bus1.sram_rdata, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        saw_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus3.sram_rvalid) saw_rvalid = 1'b1;
        end
        check("rst_flush", 32'(saw_rvalid), 32'h0);
        check("rst_flush_rdata", bus3.sram_rdata, 32'h0);
`ifdef DATA_SRAM_PERF_CNT_EN
        check("cnt_rd_rst", rd_cnt1, 32'd0);
`endif

        // Array contents survive reset
        set3(1'b1, 4'h0, 32'h8, 32'h0);
        tick();
        set3(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("retain_early", 32'(bus3.sram_rvalid), 32'h0);
        tick();
        check("retain_rvalid", 32'(bus3.sram_rvalid), 32'h1);
        check("retain_rdata", bus3.sram_rdata, 32'hA2A2_A2A2);
        set1(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("retain_rdata1", bus1.sram_rdata, 32'hDEAD_BEEF);
        set1(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
